// File: rtl/gat_pkg.sv
// Shared constants and state encoding for the streaming softmax block.
// Default parameter values live here so the top and any wrappers agree.
package gat_pkg;

    localparam int DATA_WIDTH_D  = 8;
    localparam int MAX_NODES_D   = 168;
    localparam int EXP_FRAC_D    = 11;
    localparam int ALPHA_WIDTH_D = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SUM,
        ST_DIV,
        ST_OUT
    } sm_state_e;

endpackage

// File: rtl/softmax_div.sv
// Sequential restoring divider, one quotient bit per clock after a load cycle.
// The caller guarantees dividend < divisor << QUO_W, so the quotient fits in QUO_W bits.
module softmax_div #(
    parameter int DVD_W = 23,
    parameter int DVS_W = 20,
    parameter int QUO_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [QUO_W-1:0] quotient
);

    localparam int CW = $clog2(QUO_W + 1);

    logic [DVS_W:0]   rem;
    logic [QUO_W-1:0] lo;
    logic [DVS_W-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [DVS_W:0]   trial;
    logic             fit;

    // rem stays below the divisor, so its top bit is always zero before the shift
    assign trial = {rem[DVS_W-1:0], lo[QUO_W-1]};
    assign fit   = (trial >= {1'b0, dvs});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            lo       <= '0;
            dvs      <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= (DVS_W+1)'(dividend >> QUO_W);
                lo       <= dividend[QUO_W-1:0];
                dvs      <= divisor;
                quotient <= '0;
                cnt      <= CW'(QUO_W);
            end else if (cnt != '0) begin
                rem      <= fit ? (trial - {1'b0, dvs}) : trial;
                lo       <= lo << 1;
                quotient <= {quotient[QUO_W-2:0], fit};
                cnt      <= cnt - 1'b1;
                done     <= (cnt == CW'(1));
            end
        end
    end

endmodule

// File: rtl/softmax_stream.sv
// Streaming softmax: buffers a group of signed coefficients, sums a power-of-two
// exponent approximation, then emits one normalised Q1.x weight per element.
module softmax_stream
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_D,
    parameter int MAX_NODES   = MAX_NODES_D,
    parameter int EXP_FRAC    = EXP_FRAC_D,
    parameter int ALPHA_WIDTH = ALPHA_WIDTH_D
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   coef_valid_i,
    output logic                   coef_ready_o,
    input  logic [DATA_WIDTH-1:0]  coef_i,
    input  logic                   coef_last_i,
    output logic                   alpha_valid_o,
    input  logic                   alpha_ready_i,
    output logic [ALPHA_WIDTH-1:0] alpha_o,
    output logic                   alpha_last_o,
    output logic                   busy_o,
    output logic                   ovf_o
);

    localparam int NODE_WIDTH = $clog2(MAX_NODES + 1);
    localparam int SUM_WIDTH  = EXP_FRAC + 1 + NODE_WIDTH;
    localparam int EXP_W      = EXP_FRAC + 1;
    localparam int DIFF_W     = DATA_WIDTH + 1;
    localparam int DVD_W      = EXP_W + ALPHA_WIDTH - 1;
    localparam logic [EXP_W-1:0] ONE = {1'b1, {EXP_FRAC{1'b0}}};

    sm_state_e                     state;
    logic signed [DATA_WIDTH-1:0]  mem [MAX_NODES];
    logic [NODE_WIDTH-1:0]         cnt, idx, addr, cnt_base, cnt_nxt, last_idx;
    logic signed [DATA_WIDTH-1:0]  max_q, max_nxt, rd_coef;
    logic [SUM_WIDTH-1:0]          sum_q;
    logic [DIFF_W-1:0]             diff;
    logic [EXP_W-1:0]              e_val;
    logic                          accept, forced, div_start, div_done;
    logic [ALPHA_WIDTH-1:0]        div_quo;

    assign busy_o   = (state != ST_IDLE);
    assign accept   = coef_valid_i & coef_ready_o;
    assign cnt_base = (state == ST_IDLE) ? '0 : cnt;
    assign cnt_nxt  = cnt_base + 1'b1;
    assign forced   = (cnt_base == NODE_WIDTH'(MAX_NODES - 1));
    assign last_idx = cnt - 1'b1;

    // Single port: writes land at the load pointer, reads walk idx after loading
    always_comb begin
        addr = idx;
        if (state == ST_IDLE)
            addr = '0;
        else if (state == ST_LOAD)
            addr = cnt;
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[addr] <= coef_i;
    end

    assign rd_coef = mem[addr];
    assign max_nxt = (state == ST_IDLE || $signed(coef_i) > max_q) ? $signed(coef_i) : max_q;

    // max >= every buffered coefficient, so the widened difference is non-negative
    assign diff  = {max_q[DATA_WIDTH-1], max_q} - {rd_coef[DATA_WIDTH-1], rd_coef};
    assign e_val = (int'(diff) >= EXP_W) ? '0 : (ONE >> diff);

    softmax_div #(
        .DVD_W (DVD_W),
        .DVS_W (SUM_WIDTH),
        .QUO_W (ALPHA_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({e_val, {(ALPHA_WIDTH-1){1'b0}}}),
        .divisor  (sum_q),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= '0;
            max_q         <= '0;
            sum_q         <= '0;
            coef_ready_o  <= 1'b0;
            alpha_valid_o <= 1'b0;
            alpha_o       <= '0;
            alpha_last_o  <= 1'b0;
            ovf_o         <= 1'b0;
            div_start     <= 1'b0;
        end else begin
            ovf_o     <= 1'b0;
            div_start <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    coef_ready_o <= 1'b1;
                    if (accept) begin
                        cnt   <= cnt_nxt;
                        max_q <= max_nxt;
                        state <= ST_LOAD;
                        if (coef_last_i || forced) begin
                            state        <= ST_SUM;
                            coef_ready_o <= 1'b0;
                            idx          <= '0;
                            sum_q        <= '0;
                            ovf_o        <= ~coef_last_i;
                        end
                    end
                end
                ST_SUM: begin
                    sum_q <= sum_q + SUM_WIDTH'(e_val);
                    if (idx == last_idx) begin
                        idx       <= '0;
                        state     <= ST_DIV;
                        div_start <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        alpha_o       <= div_quo;
                        alpha_valid_o <= 1'b1;
                        alpha_last_o  <= (idx == last_idx);
                        state         <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (alpha_ready_i) begin
                        alpha_valid_o <= 1'b0;
                        alpha_last_o  <= 1'b0;
                        if (idx == last_idx) begin
                            state        <= ST_IDLE;
                            coef_ready_o <= 1'b1;
                        end else begin
                            idx       <= idx + 1'b1;
                            state     <= ST_DIV;
                            div_start <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
